// File: rtl/pc_trace_streamer.sv
`timescale 1ns/1ps
// pc_trace_streamer
// Captures qualified samples (typically a CPU program counter) into a small
// FIFO and streams each one to a byte UART as a frame: SYNC_BYTE followed by
// ceil(WIDTH/8) sample bytes, least-significant byte first.
// Optional feature: define TRACE_TRIGGER_EN to hold capture off until a valid
// sample equals trig_addr; without it the streamer is permanently armed.
module pc_trace_streamer #(
  parameter int         WIDTH       = 16,
  parameter int         DEPTH       = 8,
  parameter bit         CHANGE_ONLY = 1'b1,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid,
  input  logic [WIDTH-1:0]         trig_addr,
  output logic [7:0]               tx_byte,
  output logic                     transmit,
  input  logic                     is_transmitting,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     armed
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NB = (WIDTH + 7) / 8;   // sample bytes per frame
  localparam int SW = NB * 8;            // sample padded to whole bytes
  localparam int IW = $clog2(NB + 2);    // byte index holds 0..NB+1
  localparam logic [IW-1:0] LAST_IDX = IW'(NB);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  last_val;
  logic              last_valid;
  logic [SW-1:0]     shift_reg;
  logic [IW-1:0]     byte_idx;
  logic              arm_ok;
  logic              is_new;
  logic              capture;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;

`ifdef TRACE_TRIGGER_EN
  logic armed_q;
  logic trig_hit;

  // The matching sample arms the streamer and is itself captured.
  assign trig_hit = sample_valid && (sample_in == trig_addr);
  assign arm_ok   = armed_q || trig_hit;
  assign armed    = armed_q;

  // Arm flag: set on the first trigger match, held until reset.
  always_ff @(posedge clk) begin
    if (reset)         armed_q <= 1'b0;
    else if (trig_hit) armed_q <= 1'b1;
  end
`else
  logic unused_trig;

  assign unused_trig = ^trig_addr;
  assign arm_ok      = 1'b1;
  assign armed       = 1'b1;
`endif

  // Capture qualification and FIFO handshake. A full FIFO still accepts a
  // sample when the serializer pops in the same cycle.
  assign is_new  = (CHANGE_ONLY == 1'b0) || !last_valid || (sample_in != last_val);
  assign capture = sample_valid && arm_ok && is_new;
  assign pop     = (state == LOAD);
  assign full    = (fifo_level == LW'(DEPTH));
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  // Sample storage written at the write pointer.
  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= sample_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: every clocked register uses <= so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
    end
  end

  // Last-captured value for change-only filtering, and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_val   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        last_valid <= 1'b1;
        last_val   <= sample_in;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Serializer next-state: one byte per UART busy/idle handshake.
  // NOTE: state_nxt gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if ((fifo_level != '0) && !is_transmitting) state_nxt = LOAD;
      LOAD:      state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (is_transmitting) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!is_transmitting) state_nxt = (byte_idx <= LAST_IDX) ? SEND : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Serializer datapath: load the FIFO head, then emit header and sample
  // bytes; tx_byte holds its value between sends, transmit is a 1-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      byte_idx  <= '0;
      tx_byte   <= 8'h00;
      transmit  <= 1'b0;
    end else begin
      transmit <= (state == SEND);
      case (state)
        LOAD: begin
          shift_reg <= SW'(mem[rd_ptr]);
          byte_idx  <= '0;
        end
        SEND: begin
          byte_idx <= byte_idx + IW'(1);
          if (byte_idx == '0) begin
            tx_byte <= SYNC_BYTE;
          end else begin
            tx_byte   <= shift_reg[7:0];
            shift_reg <= shift_reg >> 8;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_trace_streamer.sv
`timescale 1ns/1ps
// Self-checking bench for pc_trace_streamer. Main instance: WIDTH=16, DEPTH=4,
// change-only. Second instance: WIDTH=12, DEPTH=2, capture-every-sample.
// Expected byte streams, levels and flags come from a frame-level model.
module tb_pc_trace_streamer;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 4;
  localparam int NB       = 2;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int BUSY_CYC = 10;
  localparam logic [WIDTH-1:0] TRIG_VAL = 16'h0200;
`ifdef TRACE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] sample_in = '0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] trig_addr = TRIG_VAL;
  logic [7:0]       tx_byte;
  logic             transmit;
  logic             is_transmitting;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic             armed;

  logic [11:0] s2_in = '0;
  logic        s2_valid = 1'b0;
  logic [11:0] s2_trig = 12'hABC;
  logic [7:0]  s2_byte;
  logic        s2_tx;
  logic        s2_busy;
  logic [1:0]  s2_level;
  logic        s2_ovf;
  logic        s2_armed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_trace_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANGE_ONLY(1'b1), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_addr(trig_addr), .tx_byte(tx_byte), .transmit(transmit),
    .is_transmitting(is_transmitting), .fifo_level(fifo_level),
    .overflow(overflow), .armed(armed)
  );

  pc_trace_streamer #(.WIDTH(12), .DEPTH(2), .CHANGE_ONLY(1'b0), .SYNC_BYTE(8'hA5)) dut12 (
    .clk(clk), .reset(reset), .sample_in(s2_in), .sample_valid(s2_valid),
    .trig_addr(s2_trig), .tx_byte(s2_byte), .transmit(s2_tx),
    .is_transmitting(s2_busy), .fifo_level(s2_level),
    .overflow(s2_ovf), .armed(s2_armed)
  );

  // UART models: record each requested byte, then stay busy for a while.
  bit         stall = 1'b0;
  int         busy_cnt = 0;
  int         busy2_cnt = 0;
  logic       prev_tx = 1'b0;
  logic       prev_tx2 = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rx2_q[$];

  assign is_transmitting = stall || (busy_cnt > 0);
  assign s2_busy         = (busy2_cnt > 0);

  always @(posedge clk) begin
    if (transmit) begin
      rx_q.push_back(tx_byte);
      busy_cnt <= BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (prev_tx) begin
      n_checks++;
      assert (transmit === 1'b0) else begin
        n_fail++;
        $error("FAIL tx_back_to_back: observed %b expected 0", transmit);
      end
    end
    prev_tx <= transmit;
  end

  always @(posedge clk) begin
    if (s2_tx) begin
      rx2_q.push_back(s2_byte);
      busy2_cnt <= 3;
    end else if (busy2_cnt > 0) begin
      busy2_cnt <= busy2_cnt - 1;
    end
    if (prev_tx2) begin
      n_checks++;
      assert (s2_tx === 1'b0) else begin
        n_fail++;
        $error("FAIL tx12_back_to_back: observed %b expected 0", s2_tx);
      end
    end
    prev_tx2 <= s2_tx;
  end

  // Reference model: which samples are captured and what bytes they produce.
  logic [WIDTH-1:0] m_last = '0;
  bit               m_last_v = 1'b0;
  bit               m_armed = 1'b0;
  bit               m_ovf = 1'b0;
  int               m_count = 0;
  logic [7:0]       exp_q[$];
  logic [7:0]       exp12 [6] = '{8'hA5, 8'hBC, 8'h0A, 8'hA5, 8'hBC, 8'h0A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_armed();
    return TRIG ? m_armed : 1'b1;
  endfunction

  task automatic push_frame(input logic [WIDTH-1:0] v);
    exp_q.push_back(8'hA5);
    for (int b = 0; b < NB; b++) exp_q.push_back(8'((v >> (8 * b)) & 16'h00FF));
  endtask

  // One-cycle reset; optionally offers a trigger-matching sample during it.
  task automatic do_reset(input bit vld);
    reset        = 1'b1;
    sample_in    = TRIG_VAL;
    sample_valid = vld;
    step();
    reset        = 1'b0;
    sample_valid = 1'b0;
    rx_q.delete();
    exp_q.delete();
    m_last_v = 1'b0;
    m_armed  = 1'b0;
    m_ovf    = 1'b0;
    m_count  = 0;
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tx", transmit, 0);
    check("rst_byte", tx_byte, 8'h00);
    check("rst_armed", armed, exp_armed());
  endtask

  // Offer one sample for one cycle; pop_now marks a known same-cycle FIFO pop.
  task automatic drive(input logic [WIDTH-1:0] v, input bit vld, input bit pop_now);
    bit cap;
    sample_in    = v;
    sample_valid = vld;
    step();
    sample_valid = 1'b0;
    if (vld && (v == TRIG_VAL)) m_armed = 1'b1;
    cap = vld && (m_armed || !TRIG) && (!m_last_v || (v != m_last));
    if (cap) begin
      if ((m_count < DEPTH) || pop_now) begin
        if (!pop_now) m_count++;
        m_last   = v;
        m_last_v = 1'b1;
        push_frame(v);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // Valid only while the UART is stalled, so nothing is popped.
  task automatic check_state(input string tag);
    check($sformatf("%s_level", tag), fifo_level, m_count);
    check($sformatf("%s_ovf", tag), overflow, m_ovf);
    check($sformatf("%s_armed", tag), armed, exp_armed());
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((rx_q.size() < exp_q.size()) && (t < 4000)) begin
      step();
      t++;
    end
    repeat (40) step();
    check($sformatf("%s_in_time", tag), t < 4000, 1);
    check($sformatf("%s_nbytes", tag), rx_q.size(), exp_q.size());
    for (int i = 0; (i < exp_q.size()) && (i < rx_q.size()); i++)
      check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
    check($sformatf("%s_empty", tag), fifo_level, 0);
    rx_q.delete();
    exp_q.delete();
    m_count = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] pool [3];
    int t;

    // Repeated value filtered, header latency of three edges, two frames.
    do_reset(1'b0);
    drive(16'h0200, 1'b1, 1'b0);
    check("lat_level", fifo_level, 1);
    drive(16'h0200, 1'b1, 1'b0);
    check("lat_tx_n1", transmit, 0);
    drive(16'h0203, 1'b1, 1'b0);
    check("lat_tx_n2", transmit, 0);
    check("dup_level", fifo_level, 1);
    step();
    check("lat_tx_n3", transmit, 1);
    check("lat_hdr", tx_byte, 8'hA5);
    wait_drain("two_frames");
    check("two_frames_ovf", overflow, 0);

    // Full FIFO accepts a capture in the cycle the serializer pops.
    stall = 1'b1;
    do_reset(1'b0);
    drive(16'h0200, 1'b1, 1'b0); check_state("fill1");
    drive(16'h1111, 1'b1, 1'b0); check_state("fill2");
    drive(16'h2222, 1'b1, 1'b0); check_state("fill3");
    drive(16'h3333, 1'b1, 1'b0); check_state("fill4");
    stall = 1'b0;
    step();
    drive(16'h4444, 1'b1, 1'b1);
    check_state("pop_push");
    wait_drain("pop_push_frames");

    // Six distinct samples into a stalled UART: last two are dropped.
    stall = 1'b1;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(16'h0200 + 16'(i * 16'h0111), 1'b1, 1'b0);
      check_state($sformatf("ovf_fill%0d", i));
    end
    stall = 1'b0;
    wait_drain("ovf_frames");

    // Random samples from a small pool (repeats and trigger hits likely).
    for (int r = 0; r < 2; r++) begin
      stall = 1'b1;
      do_reset(1'b0);
      pool[0] = TRIG_VAL;
      pool[1] = 16'($urandom);
      pool[2] = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        drive(pool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 1'b0);
        check_state($sformatf("rnd%0d_%0d", r, i));
      end
      stall = 1'b0;
      wait_drain($sformatf("rnd%0d_frames", r));
    end

    // Trigger sequence: nothing before 0x0200 when the trigger is built in.
    do_reset(1'b0);
    drive(16'h0100, 1'b1, 1'b0);
    check("trig_a_armed", armed, exp_armed());
    step();
    drive(16'h0200, 1'b1, 1'b0);
    check("trig_b_armed", armed, exp_armed());
    drive(16'h0201, 1'b1, 1'b0);
    check("trig_c_armed", armed, exp_armed());
    wait_drain("trig_frames");

    // Reset in WAIT_IDLE after the first sample byte aborts the frame;
    // a sample offered during reset is discarded.
    do_reset(1'b0);
    drive(16'h1234, 1'b1, 1'b0);
    t = 0;
    while ((rx_q.size() < 2) && (t < 500)) begin
      step();
      t++;
    end
    check("abort_two_bytes", rx_q.size(), 2);
    repeat (3) step();
    do_reset(1'b1);
    repeat (60) step();
    check("abort_no_tx", rx_q.size(), 0);
    check("abort_level", fifo_level, 0);
    check("abort_ovf", overflow, 0);
    check("abort_armed", armed, exp_armed());

    // WIDTH=12 instance: padded top byte, every valid sample captured.
    s2_in    = 12'hABC;
    s2_valid = 1'b1;
    step();
    step();
    s2_valid = 1'b0;
    check("w12_level", s2_level, 2);
    t = 0;
    while ((rx2_q.size() < 6) && (t < 500)) begin
      step();
      t++;
    end
    repeat (20) step();
    check("w12_nbytes", rx2_q.size(), 6);
    for (int i = 0; (i < 6) && (i < rx2_q.size()); i++)
      check($sformatf("w12_b%0d", i), rx2_q[i], exp12[i]);
    check("w12_empty", s2_level, 0);
    check("w12_ovf", s2_ovf, 0);
    check("w12_armed", s2_armed, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_trace_streamer.md
PC_TRACE_STREAMER -- requirements
Module: pc_trace_streamer

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits, 8..32.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, 2..64.
REQ-003 Parameter CHANGE_ONLY, default 1: 1 = capture only when the sample differs from the last captured value; 0 = capture every valid sample.
REQ-004 Parameter SYNC_BYTE, default 8'hA5: frame header byte sent before each sample.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sample_in  input  WIDTH  value to trace, e.g. the CPU program counter.
REQ-008 sample_valid  input  1  sample_in is qualified this cycle.
REQ-009 trig_addr  input  WIDTH  arm value; used only with TRACE_TRIGGER_EN.
REQ-010 tx_byte  output  8  byte offered to the UART.
REQ-011 transmit  output  1  one-cycle request to the UART to send tx_byte.
REQ-012 is_transmitting  input  1  UART busy flag.
REQ-013 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: a sample was dropped.
REQ-015 armed  output  1  capture enabled.

Function
REQ-016 Capture condition: sample_valid and armed and (CHANGE_ONLY==0, or sample_in != last captured value, or no capture since reset).
REQ-017 A captured sample SHALL be written into the FIFO on the same edge and SHALL update the last-captured register.
REQ-018 Capture with the FIFO full and no pop in that cycle: sample dropped, overflow set to 1, last-captured register unchanged.
REQ-019 Capture with the FIFO full and a pop in the same cycle: sample accepted, level unchanged.
REQ-020 Each frame SHALL be SYNC_BYTE, then NB = ceil(WIDTH/8) sample bytes, least-significant byte first, with unused upper bits of the top byte sent as 0.
REQ-021 The serializer FSM SHALL have states IDLE, LOAD, SEND, WAIT_BUSY and WAIT_IDLE.
REQ-022 IDLE -> LOAD when the FIFO is non-empty and is_transmitting=0.
REQ-023 LOAD: pop the FIFO head into the shift register, set byte index to 0 (header), then go to SEND.
REQ-024 SEND: drive tx_byte and pulse transmit=1 for exactly one cycle, then go to WAIT_BUSY; tx_byte SHALL be held until the next SEND.
REQ-025 WAIT_BUSY: stay until is_transmitting=1, then go to WAIT_IDLE.
REQ-026 WAIT_IDLE: stay until is_transmitting=0; then go to SEND for the next byte if bytes remain, else go to IDLE.
REQ-027 Latency: with the FIFO empty, FSM in IDLE and UART idle, a capture at edge N SHALL produce the header transmit pulse at edge N+3.
REQ-028 fifo_level SHALL count 0..DEPTH exactly; read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Only one transmit pulse SHALL be issued per byte; transmit is never high in two consecutive cycles.

Reset
REQ-030 On reset: FSM to IDLE, FIFO emptied, fifo_level=0, transmit=0, tx_byte=8'h00, overflow=0, last-captured register invalidated.
REQ-031 Reset mid-frame SHALL abort the frame; no further bytes of that frame are sent after reset deasserts.
REQ-032 Reset dominates a capture occurring in the same cycle; the sample is discarded.

Configuration
REQ-033 Macro TRACE_TRIGGER_EN defined: armed=0 after reset; armed is set by a valid sample equal to trig_addr, that sample is captured, and armed stays 1 until reset.
REQ-034 Macro TRACE_TRIGGER_EN undefined: armed is constant 1 and trig_addr is ignored.

Verification
REQ-035 WIDTH=16, UART model busy 10 cycles per byte; valid samples 0x0200, 0x0200, 0x0203 -> two frames: A5 00 02, then A5 03 02; overflow=0.
REQ-036 DEPTH=4, UART stalled busy; 6 distinct valid samples -> fifo_level reaches 4, overflow=1; after UART release, exactly the first 4 samples are sent in order.
REQ-037 WIDTH=12, sample 0xABC -> bytes A5 BC 0A.
REQ-038 TRACE_TRIGGER_EN defined, trig_addr=0x0200; samples 0x0100, 0x0200, 0x0201 -> armed rises at 0x0200; frames only for 0x0200 and 0x0201.
REQ-039 Assert reset while the FSM is in WAIT_IDLE after the first sample byte -> no further transmit pulses, fifo_level=0, overflow=0.
REQ-040 Full FIFO with capture and pop (LOAD) in the same cycle -> fifo_level stays DEPTH, overflow stays 0.
